slc3_io_responder: RTL and testbench

Memory-mapped I/O responder for the SLC-3 core. It sits between the CPU memory port and the board user interface: switches, Run/Continue buttons, hex displays and LEDs.
- Answers CPU reads and writes at the I/O address.
- Conditions the raw buttons into clean single-cycle events.
- Runs the PAUSE/Continue handshake the CPU relies on.

---
 rtl/slc3_io_pkg.sv | 43 ++++
 rtl/slc3_io_responder_button_conditioner.sv | 57 +++++
 rtl/slc3_io_responder.sv | 156 +++++++++++++++
 tb/tb_slc3_io_responder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_io_pkg.sv
// ----------------------------------------------------------------------------
// slc3_io_pkg : shared types, constants and seven-segment decode for slc3_io
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package slc3_io_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2
   } pause_state_t;

   localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

   // Active-low segments, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_to_sevenseg(input logic [3:0] i_nibble);
      logic [6:0] w_seg;
      case (i_nibble)
         4'h0:    w_seg = 7'b1000000;
         4'h1:    w_seg = 7'b1111001;
         4'h2:    w_seg = 7'b0100100;
         4'h3:    w_seg = 7'b0110000;
         4'h4:    w_seg = 7'b0011001;
         4'h5:    w_seg = 7'b0010010;
         4'h6:    w_seg = 7'b0000010;
         4'h7:    w_seg = 7'b1111000;
         4'h8:    w_seg = 7'b0000000;
         4'h9:    w_seg = 7'b0010000;
         4'hA:    w_seg = 7'b0001000;
         4'hB:    w_seg = 7'b0000011;
         4'hC:    w_seg = 7'b1000110;
         4'hD:    w_seg = 7'b0100001;
         4'hE:    w_seg = 7'b0000110;
         default: w_seg = 7'b0001110;
      endcase
      return w_seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/slc3_io_responder_button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner : 2-flop synchronizer, debounce counter, press pulse
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw_n,
   output logic o_press,
   output logic o_level
);

   localparam logic [15:0] C_LIMIT = 16'(DEBOUNCE_CYCLES);

   logic        r_sync1;
   logic        r_sync2;
   logic        r_level;
   logic        r_level_d;
   logic        r_press;
   logic [15:0] r_cnt;

   // The level flips on the sample after the counter has reached the limit,
   // and the press pulse is taken from the delayed copy of the level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_level   <= 1'b1;
         r_level_d <= 1'b1;
         r_press   <= 1'b0;
         r_cnt     <= 16'd0;
      end else begin
         r_sync1   <= i_raw_n;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         r_press   <= r_level_d & ~r_level;
         if (r_sync2 == r_level) begin
            r_cnt <= 16'd0;
         end else if (r_cnt == C_LIMIT) begin
            r_level <= r_sync2;
            r_cnt   <= 16'd0;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   assign o_press = r_press;
   assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/slc3_io_responder.sv
// ----------------------------------------------------------------------------
// slc3_io_responder : SLC-3 memory-mapped switch/hex I/O and PAUSE handshake
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module slc3_io_responder
   import slc3_io_pkg::*;
#(
   parameter logic [15:0] IO_ADDR         = IO_ADDR_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] ADDR,
   input  logic        MEM_RD,
   input  logic        MEM_WR,
   input  logic [15:0] Data_from_CPU,
   input  logic [15:0] Data_from_SRAM,
   output logic [15:0] Data_to_CPU,
   output logic        RDY,
   input  logic [9:0]  SW,
   input  logic        Run_n,
   input  logic        Continue_n,
   input  logic        Pause_Req,
   input  logic [9:0]  LED_Pattern,
   output logic        Pause_Ack,
   output logic        Run_Pulse,
   output logic        Continue_Pulse,
   output logic [9:0]  LED,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3
);

   logic [9:0]   r_sw_sync1;
   logic [9:0]   r_sw_sync2;
   logic [15:0]  r_data_to_cpu;
   logic         r_rdy;
   logic [15:0]  r_hex;
   pause_state_t r_state;
   pause_state_t w_next_state;
   logic [9:0]   r_led;
   logic [9:0]   w_next_led;
   logic         r_pause_ack;
   logic         w_next_ack;
   logic         w_io_hit;
   logic         w_run_press;
   logic         w_run_level_unused;
   logic         w_cont_press;
   logic         w_cont_level;

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
      .clk     (Clk),
      .rst     (Reset),
      .i_raw_n (Run_n),
      .o_press (w_run_press),
      .o_level (w_run_level_unused)
   );

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont_btn (
      .clk     (Clk),
      .rst     (Reset),
      .i_raw_n (Continue_n),
      .o_press (w_cont_press),
      .o_level (w_cont_level)
   );

   assign w_io_hit = (ADDR == IO_ADDR);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_sw_sync1 <= 10'd0;
         r_sw_sync2 <= 10'd0;
      end else begin
         r_sw_sync1 <= SW;
         r_sw_sync2 <= r_sw_sync1;
      end
   end

   // A write takes priority over a simultaneous read; read data then holds.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_data_to_cpu <= 16'd0;
         r_rdy         <= 1'b0;
         r_hex         <= 16'd0;
      end else begin
         r_rdy <= MEM_RD | MEM_WR;
         if (MEM_WR) begin
            if (w_io_hit) begin
               r_hex <= Data_from_CPU;
            end
         end else if (MEM_RD) begin
            r_data_to_cpu <= w_io_hit ? {6'b0, r_sw_sync2} : Data_from_SRAM;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_led       <= 10'd0;
         r_pause_ack <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_led       <= w_next_led;
         r_pause_ack <= w_next_ack;
      end
   end

   // Pause_Req is ignored while Pause_Ack is high: the CPU only sees the
   // acknowledge at the end of that cycle and drops its request afterwards.
   always_comb begin
      w_next_state = r_state;
      w_next_led   = r_led;
      w_next_ack   = 1'b0;
      case (r_state)
         IDLE: begin
            if (Pause_Req && !r_pause_ack) begin
               w_next_led   = LED_Pattern;
               w_next_state = WAIT_PRESS;
            end
         end
         WAIT_PRESS: begin
            if (w_cont_press) begin
               w_next_state = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (w_cont_level) begin
               w_next_ack   = 1'b1;
               w_next_led   = 10'd0;
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign Data_to_CPU    = r_data_to_cpu;
   assign RDY            = r_rdy;
   assign Pause_Ack      = r_pause_ack;
   assign Run_Pulse      = w_run_press;
   assign Continue_Pulse = w_cont_press;
   assign LED            = r_led;
   assign HEX0           = hex_to_sevenseg(r_hex[3:0]);
   assign HEX1           = hex_to_sevenseg(r_hex[7:4]);
   assign HEX2           = hex_to_sevenseg(r_hex[11:8]);
   assign HEX3           = hex_to_sevenseg(r_hex[15:12]);

endmodule

`default_nettype wire

// File: tb/tb_slc3_io_responder.sv
// ----------------------------------------------------------------------------
// tb_slc3_io_responder : randomized self-checking bench for slc3_io_responder
// Revision             : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_slc3_io_responder;

   localparam int D = 4;
   localparam logic [6:0] SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] ADDR = 16'h0;
   logic        MEM_RD = 1'b0;
   logic        MEM_WR = 1'b0;
   logic [15:0] Data_from_CPU = 16'h0;
   logic [15:0] Data_from_SRAM = 16'h0;
   logic [15:0] Data_to_CPU;
   logic        RDY;
   logic [9:0]  SW = 10'h0;
   logic        Run_n = 1'b1;
   logic        Continue_n = 1'b1;
   logic        Pause_Req = 1'b0;
   logic [9:0]  LED_Pattern = 10'h0;
   logic        Pause_Ack;
   logic        Run_Pulse;
   logic        Continue_Pulse;
   logic [9:0]  LED;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] sram;
      logic [9:0]  sw;
   } xact_t;

   always #5 Clk = ~Clk;

   slc3_io_responder #(.IO_ADDR(16'hFFFF), .DEBOUNCE_CYCLES(D)) dut (
      .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
      .Data_from_CPU(Data_from_CPU), .Data_from_SRAM(Data_from_SRAM),
      .Data_to_CPU(Data_to_CPU), .RDY(RDY), .SW(SW), .Run_n(Run_n),
      .Continue_n(Continue_n), .Pause_Req(Pause_Req), .LED_Pattern(LED_Pattern),
      .Pause_Ack(Pause_Ack), .Run_Pulse(Run_Pulse), .Continue_Pulse(Continue_Pulse),
      .LED(LED), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3));

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Holds one button low for len edges, then observes until total edges.
   // Drops Pause_Req as soon as Pause_Ack is seen, as the CPU would.
   task automatic press(input bit is_run, input int len, input int total,
                        output int acks, output int ack_n, output bit ack_led_ok,
                        output int cp, output int cp_n, output int rp, output int rp_n);
      acks = 0; ack_n = 0; ack_led_ok = 1'b1; cp = 0; cp_n = 0; rp = 0; rp_n = 0;
      if (is_run) Run_n = 1'b0; else Continue_n = 1'b0;
      for (int n = 1; n <= total; n++) begin
         tick();
         if (n == len) begin Run_n = 1'b1; Continue_n = 1'b1; end
         if (Pause_Ack === 1'b1) begin
            acks++;
            if (ack_n == 0) ack_n = n;
            if (LED !== 10'h0) ack_led_ok = 1'b0;
            Pause_Req = 1'b0;
         end
         if (Continue_Pulse === 1'b1) begin cp++; if (cp_n == 0) cp_n = n; end
         if (Run_Pulse === 1'b1) begin rp++; if (rp_n == 0) rp_n = n; end
      end
   endtask

   task automatic test_reset();
      int pulses;
      Reset = 1'b1;
      tick(); tick();
      checks++;
      if ({Data_to_CPU, RDY, Pause_Ack, Run_Pulse, Continue_Pulse, LED} !== 30'h0) begin
         errors++;
         $display("FAIL reset_outputs got data=%h rdy=%b ack=%b rp=%b cp=%b led=%h exp all zero",
                  Data_to_CPU, RDY, Pause_Ack, Run_Pulse, Continue_Pulse, LED);
      end
      checks++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {4{7'b1000000}}) begin
         errors++;
         $display("FAIL reset_hex got %h %h %h %h exp 40 40 40 40", HEX3, HEX2, HEX1, HEX0);
      end
      Reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (RDY !== 1'b0 || Pause_Ack !== 1'b0 || Run_Pulse !== 1'b0 ||
             Continue_Pulse !== 1'b0 || LED !== 10'h0) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL idle_quiet got %0d active cycles exp 0", pulses);
      end
   endtask

   task automatic test_memory();
      xact_t       xq[$];
      xact_t       x;
      logic [15:0] m_data = 16'h0;
      logic [15:0] m_hex = 16'h0;
      logic        exp_rdy;
      xq.push_back('{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, 10'h031});
      xq.push_back('{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 10'h031});
      xq.push_back('{1'b0, 1'b1, 16'hFFFF, 16'h1A2B, 16'h0000, 10'h031});
      xq.push_back('{1'b0, 1'b1, 16'h0020, 16'h5555, 16'h0000, 10'h031});
      xq.push_back('{1'b1, 1'b1, 16'hFFFF, 16'h0F0F, 16'h7777, 10'h3C5});
      for (int i = 0; i < 24; i++) begin
         x.rd    = 1'($urandom_range(0, 1));
         x.wr    = 1'($urandom_range(0, 1));
         x.addr  = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
         x.wdata = 16'($urandom);
         x.sram  = 16'($urandom);
         x.sw    = 10'($urandom);
         xq.push_back(x);
      end
      foreach (xq[k]) begin
         SW = xq[k].sw;
         tick(); tick();
         ADDR = xq[k].addr; MEM_RD = xq[k].rd; MEM_WR = xq[k].wr;
         Data_from_CPU = xq[k].wdata; Data_from_SRAM = xq[k].sram;
         tick();
         MEM_RD = 1'b0; MEM_WR = 1'b0;
         exp_rdy = xq[k].rd | xq[k].wr;
         if (xq[k].wr) begin
            if (xq[k].addr == 16'hFFFF) m_hex = xq[k].wdata;
         end else if (xq[k].rd) begin
            m_data = (xq[k].addr == 16'hFFFF) ? {6'b0, xq[k].sw} : xq[k].sram;
         end
         checks++;
         if ({Data_to_CPU, RDY} !== {m_data, exp_rdy}) begin
            errors++;
            $display("FAIL mem_resp[%0d] got data=%h rdy=%b exp data=%h rdy=%b",
                     k, Data_to_CPU, RDY, m_data, exp_rdy);
         end
         checks++;
         if ({HEX3, HEX2, HEX1, HEX0} !== {SEG[m_hex[15:12]], SEG[m_hex[11:8]],
                                           SEG[m_hex[7:4]], SEG[m_hex[3:0]]}) begin
            errors++;
            $display("FAIL mem_hex[%0d] got %h %h %h %h exp hex value %h",
                     k, HEX3, HEX2, HEX1, HEX0, m_hex);
         end
         tick();
         checks++;
         if ({Data_to_CPU, RDY} !== {m_data, 1'b0}) begin
            errors++;
            $display("FAIL mem_hold[%0d] got data=%h rdy=%b exp data=%h rdy=0",
                     k, Data_to_CPU, RDY, m_data);
         end
      end
   endtask

   task automatic test_debounce();
      int lens[$];
      bit runs[$];
      int acks, ack_n, cp, cp_n, rp, rp_n, tp, tp_n, op;
      bit led_ok, exp_pulse;
      lens.push_back(3);  runs.push_back(1'b0);
      lens.push_back(20); runs.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         runs.push_back(1'($urandom_range(0, 1)));
         lens.push_back(($urandom_range(0, 1) == 1) ? $urandom_range(1, D - 1)
                                                     : $urandom_range(D + 4, 20));
      end
      Pause_Req = 1'b0;
      foreach (lens[k]) begin
         press(runs[k], lens[k], 40, acks, ack_n, led_ok, cp, cp_n, rp, rp_n);
         tp   = runs[k] ? rp : cp;
         tp_n = runs[k] ? rp_n : cp_n;
         op   = runs[k] ? cp : rp;
         exp_pulse = (lens[k] >= D + 1);
         checks++;
         if (exp_pulse ? (tp != 1 || tp_n != D + 4) : (tp != 0)) begin
            errors++;
            $display("FAIL debounce[%0d] run=%0d len=%0d got %0d pulses first at edge %0d exp %0d at edge %0d",
                     k, runs[k], lens[k], tp, tp_n, exp_pulse ? 1 : 0, D + 4);
         end
         checks++;
         if (op != 0 || acks != 0) begin
            errors++;
            $display("FAIL debounce_cross[%0d] got other pulses=%0d acks=%0d exp 0 0", k, op, acks);
         end
      end
   endtask

   task automatic test_pause();
      int acks, ack_n, cp, cp_n, rp, rp_n, len;
      bit led_ok;
      logic [9:0] pat;
      for (int t = 0; t < 3; t++) begin
         pat = (t == 0) ? 10'h2AA : 10'($urandom);
         LED_Pattern = pat;
         Pause_Req = 1'b1;
         tick(); tick();
         LED_Pattern = ~pat;
         for (int w = $urandom_range(0, 5); w > 0; w--) tick();
         checks++;
         if (LED !== pat) begin
            errors++;
            $display("FAIL pause_led[%0d] got %h exp %h", t, LED, pat);
         end
         len = $urandom_range(8, 15);
         press(1'b0, len, 40, acks, ack_n, led_ok, cp, cp_n, rp, rp_n);
         checks++;
         if (acks != 1 || ack_n <= len || ack_n > len + D + 10 || cp != 1) begin
            errors++;
            $display("FAIL pause_ack[%0d] got acks=%0d at edge %0d cp=%0d exp 1 ack in (%0d,%0d] cp=1",
                     t, acks, ack_n, cp, len, len + D + 10);
         end
         checks++;
         if (!led_ok || LED !== 10'h0 || Pause_Ack !== 1'b0) begin
            errors++;
            $display("FAIL pause_end[%0d] got led=%h ack=%b led_at_ack_zero=%0d exp led=0 ack=0",
                     t, LED, Pause_Ack, led_ok);
         end
      end
   endtask

   task automatic test_pause_guard();
      int acks, ack_n, cp, cp_n, rp, rp_n;
      bit led_ok;
      logic [9:0] pat;
      pat = 10'($urandom) | 10'h001;
      Continue_n = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      LED_Pattern = pat;
      Pause_Req = 1'b1;
      tick(); tick(); tick();
      Continue_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (Pause_Ack === 1'b1) acks++;
      end
      checks++;
      if (acks != 0 || LED !== pat) begin
         errors++;
         $display("FAIL stale_press got acks=%0d led=%h exp acks=0 led=%h", acks, LED, pat);
      end
      press(1'b1, 10, 30, acks, ack_n, led_ok, cp, cp_n, rp, rp_n);
      checks++;
      if (acks != 0 || rp != 1 || cp != 0 || LED !== pat) begin
         errors++;
         $display("FAIL run_in_pause got acks=%0d rp=%0d cp=%0d led=%h exp 0 1 0 %h",
                  acks, rp, cp, LED, pat);
      end
      press(1'b0, 10, 40, acks, ack_n, led_ok, cp, cp_n, rp, rp_n);
      checks++;
      if (acks != 1 || !led_ok || LED !== 10'h0) begin
         errors++;
         $display("FAIL guard_release got acks=%0d led=%h exp acks=1 led=0", acks, LED);
      end
   endtask

   task automatic test_reset_mid_pause();
      int acks, ack_n, cp, cp_n, rp, rp_n;
      bit led_ok;
      LED_Pattern = 10'h155;
      Pause_Req = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (LED !== 10'h155) begin
         errors++;
         $display("FAIL rst_pause_entry got led=%h exp 155", LED);
      end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if (LED !== 10'h0 || Pause_Ack !== 1'b0) begin
         errors++;
         $display("FAIL rst_pause_async got led=%h ack=%b exp led=0 ack=0", LED, Pause_Ack);
      end
      Pause_Req = 1'b0;
      tick(); tick();
      Reset = 1'b0;
      press(1'b0, 10, 40, acks, ack_n, led_ok, cp, cp_n, rp, rp_n);
      checks++;
      if (acks != 0 || LED !== 10'h0 || cp != 1) begin
         errors++;
         $display("FAIL rst_pause_idle got acks=%0d led=%h cp=%0d exp 0 0 1", acks, LED, cp);
      end
   endtask

   task automatic test_reset_mid_debounce();
      int pulses;
      Continue_n = 1'b0;
      Run_n = 1'b0;
      tick(); tick(); tick(); tick();
      #2 Reset = 1'b1;
      Continue_n = 1'b1;
      Run_n = 1'b1;
      tick(); tick();
      Reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (Continue_Pulse !== 1'b0 || Run_Pulse !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL rst_debounce got %0d pulse cycles exp 0", pulses);
      end
   endtask

   initial begin
      test_reset();
      test_memory();
      test_debounce();
      test_pause();
      test_pause_guard();
      test_reset_mid_pause();
      test_reset_mid_debounce();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
